v_rams_sp_param: RTL and testbench
==================================

V_RAMS_SP_PARAM -- requirements
Module: v_rams_sp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width; SHALL be a multiple of BYTE_W.
REQ-002 SHALL have parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter BYTE_W, default 8, byte-lane width; NB = DATA_W/BYTE_W lanes.
REQ-004 SHALL have parameter WRITE_MODE, default 0, port mode: 0 write-first, 1 read-first, 2 no-change.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port en, input, 1, access enable.
REQ-008 SHALL have port we, input, NB, per-lane write enable; any bit set means write access.
REQ-009 SHALL have port addr, input, ADDR_W, word address.
REQ-010 SHALL have port di, input, DATA_W, write data.
REQ-011 SHALL have port clr, input, 1, single-cycle request to zero the whole array.
REQ-012 SHALL have port do, output, DATA_W, registered read data.
REQ-013 SHALL have port do_vld, output, 1, do updated this cycle.
REQ-014 SHALL have port busy, output, 1, clear sweep in progress; accesses ignored.

Function
REQ-015 Access SHALL be accepted only when en=1 and busy=0; otherwise array, do and do_vld (forced 0) SHALL be unaffected.
REQ-016 Write SHALL update only lanes with we[i]=1; other lanes keep old content.
REQ-017 Read (we=0) SHALL return RAM[addr] on do one cycle later with do_vld=1.
REQ-018 Write, WRITE_MODE=0: do SHALL show the merged new word (new lanes where we set, old elsewhere), do_vld=1.
REQ-019 Write, WRITE_MODE=1: do SHALL show the pre-write word, do_vld=1.
REQ-020 Write, WRITE_MODE=2: do SHALL hold its previous value, do_vld=0.
REQ-021 Clear FSM states: CLEAR (busy=1, write zero to counter address, counter+1 per cycle) and READY (busy=0).
REQ-022 CLEAR SHALL take exactly DEPTH cycles, addresses 0..DEPTH-1 ascending, then go to READY; counter wraps to 0.
REQ-023 clr=1 in READY SHALL enter CLEAR next cycle; clr=1 in CLEAR SHALL restart the sweep at address 0.
REQ-024 clr and an accepted access in the same cycle: the access SHALL complete, then the clear SHALL start.
REQ-025 do SHALL not be modified by the clear sweep.

Reset
REQ-026 rst SHALL set state CLEAR, counter 0, busy=1, do=0, do_vld=0; array cleared by the ensuing sweep.
REQ-027 rst asserted mid-sweep or mid-access SHALL abandon it and restart the sweep at address 0.

Configuration
REQ-028 With macro V_RAMS_OUT_REG_EN defined, do and do_vld SHALL pass through one extra register (read latency 2, reset to 0).
REQ-029 Without V_RAMS_OUT_REG_EN, read latency SHALL be 1 and no extra register SHALL exist.

Structure
REQ-030 Package v_rams_pkg SHALL hold WRITE_MODE constants (WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2) and the clear-state typedef (CLEAR, READY).
REQ-031 Sub-module v_rams_clr_seq SHALL implement the clear FSM and address counter, outputting busy, clear address and clear write strobe.
REQ-032 Array SHALL be inferable as block RAM: one port, one write per cycle, muxing clear and user access.

Verification (defaults, no macro unless stated)
REQ-033 rst 1 cycle, then idle -> busy=1 exactly 64 cycles; all 64 addresses subsequently read 0x0000.
REQ-034 Write 0xBEEF to addr 5, we=2'b11, mode 0 -> next cycle do=0xBEEF, do_vld=1; read addr 5 -> 0xBEEF.
REQ-035 addr 5 holds 0xBEEF, write 0x1234 with we=2'b01: mode 0 -> do=0xBE34; mode 1 -> do=0xBEEF; mode 2 -> do unchanged, do_vld=0; final content 0xBE34.
REQ-036 en=1 read while busy=1 -> do_vld=0, do unchanged; clr pulse at sweep cycle 30 -> busy stays 1 for 64 more cycles.
REQ-037 V_RAMS_OUT_REG_EN defined, read addr 63 holding 0xA5A5 -> do=0xA5A5, do_vld=1 exactly 2 cycles after request.
REQ-038 rst at sweep cycle 10 after writing 0xFFFF to addr 40 -> new 64-cycle sweep; addr 40 reads 0x0000.

Source files
------------

// File: rtl/v_rams_pkg.sv
// Shared constants and types for the single-port byte-lane RAM with clear sweep.
package v_rams_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/v_rams_clr_seq.sv
// Clear sequencer: sweeps every word address in ascending order, one per cycle,
// while busy. Reset and clr requests both (re)start the sweep at address 0.
module v_rams_clr_seq
  import v_rams_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              clr_we_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a clr request always restarts from address 0, even mid-sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_i) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: while clearing, every cycle writes zero at the counter address.
  always_comb begin
    busy_o     = (state_q == CLEAR);
    clr_we_o   = (state_q == CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/v_rams_sp_param.sv
// Single-port RAM with per-byte-lane write enables, selectable write mode
// (write-first / read-first / no-change) and a whole-array clear sweep.
// Optional macro V_RAMS_OUT_REG_EN adds one output register stage (latency 2).
module v_rams_sp_param
  import v_rams_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 6,
  parameter int BYTE_W     = 8,
  parameter int WRITE_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [DATA_W/BYTE_W-1:0]   we_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DATA_W-1:0]          di_i,
  input  logic                       clr_i,
  output logic [DATA_W-1:0]          do_o,
  output logic                       do_vld_o,
  output logic                       busy_o
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  // Replace the lanes selected by be with the corresponding lanes of new_w.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              acc;
  logic              is_wr;
  logic              upd;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] do_d;
  logic [DATA_W-1:0] do_q;
  logic              vld_q;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;

  v_rams_clr_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_i),
    .busy_o    (busy),
    .clr_addr_o(clr_addr),
    .clr_we_o  (clr_we)
  );

  assign busy_o = busy;

  // Access qualification and read-data selection for the output register.
  always_comb begin
    acc     = en_i & ~busy & ~rst;
    is_wr   = |we_i;
    rd_word = mem[addr_i];
    upd     = acc & ~(is_wr && (WRITE_MODE == WM_NO_CHANGE));
    if (is_wr && (WRITE_MODE == WM_WRITE_FIRST)) do_d = lane_merge(rd_word, di_i, we_i);
    else                                         do_d = rd_word;
  end

  // Single write port shared by the clear sweep and user writes.
  always_comb begin
    wr_addr = addr_i;
    wr_data = di_i;
    wr_be   = '0;
    if (clr_we) begin
      wr_addr = clr_addr;
      wr_data = '0;
      wr_be   = '1;
    end else if (acc) begin
      wr_be   = we_i;
    end
  end

  // Array write with per-lane enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Registered read data; held when no accepted access updates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= upd;
      if (upd) do_q <= do_d;
    end
  end

`ifdef V_RAMS_OUT_REG_EN
  logic [DATA_W-1:0] do_r_q;
  logic              vld_r_q;

  // Extra output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_r_q  <= '0;
      vld_r_q <= 1'b0;
    end else begin
      do_r_q  <= do_q;
      vld_r_q <= vld_q;
    end
  end

  assign do_o     = do_r_q;
  assign do_vld_o = vld_r_q;
`else
  assign do_o     = do_q;
  assign do_vld_o = vld_q;
`endif

endmodule

// File: tb/tb_v_rams_sp_param.sv
// Scoreboard bench: three RAM instances (one per write mode) share stimulus;
// a reference model predicts per-cycle busy and per-mode output expectations.
module tb_v_rams_sp_param;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 64;
`ifdef V_RAMS_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [NB-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic [3*DW-1:0] dout_all;
  logic [2:0]      vld_all;
  logic [2:0]      bsy_all;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    v_rams_sp_param #(
      .DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW), .WRITE_MODE(g)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .we_i    (we),
      .addr_i  (addr),
      .di_i    (di),
      .clr_i   (clr),
      .do_o    (dout_all[g*DW +: DW]),
      .do_vld_o(vld_all[g]),
      .busy_o  (bsy_all[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output for one cycle: per mode, valid with data, hold, or forced zero.
  typedef struct {
    int          due;
    logic [2:0]  v;
    logic [2:0]  hold;
    logic [47:0] d;
  } exp_t;

  exp_t          sbq[$];
  bit            exp_busy[int];
  logic [DW-1:0] mem_m [DEPTH];
  int            bz;
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] hold_do [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard once per cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_busy.exists(cyc)) begin
      for (int m = 0; m < 3; m++) chk($sformatf("busy_m%0d", m), 32'(bsy_all[m]), 32'(exp_busy[cyc]));
      exp_busy.delete(cyc);
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      for (int m = 0; m < 3; m++) begin
        if (e.v[m]) begin
          chk($sformatf("vld_m%0d", m), 32'(vld_all[m]), 32'd1);
          chk($sformatf("do_m%0d", m), 32'(dout_all[m*DW +: DW]), 32'(e.d[m*DW +: DW]));
          hold_do[m] = e.d[m*DW +: DW];
        end else if (e.hold[m]) begin
          chk($sformatf("vld_m%0d", m), 32'(vld_all[m]), 32'd0);
          chk($sformatf("do_hold_m%0d", m), 32'(dout_all[m*DW +: DW]), 32'(hold_do[m]));
        end else begin
          chk($sformatf("vld_rst_m%0d", m), 32'(vld_all[m]), 32'd0);
          chk($sformatf("do_rst_m%0d", m), 32'(dout_all[m*DW +: DW]), 32'd0);
          hold_do[m] = '0;
        end
      end
    end
  end

  // Apply one cycle of stimulus and record what the model predicts for it.
  task automatic step(input bit r, input bit e_, input logic [NB-1:0] w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input bit c);
    exp_t          x;
    logic [DW-1:0] old_w, new_w;
    @(negedge clk);
    rst = r; en = e_; we = w; addr = a; di = d; clr = c;
    x.due  = cyc + LAT;
    x.v    = 3'b000;
    x.hold = 3'b111;
    x.d    = '0;
    if (r) begin
      foreach (sbq[i]) begin
        if (sbq[i].due > cyc) begin
          sbq[i].v    = 3'b000;
          sbq[i].hold = 3'b000;
          sbq[i].d    = '0;
        end
      end
      x.hold = 3'b000;
      bz = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else begin
      if (e_ && bz == 0) begin
        old_w = mem_m[a];
        new_w = old_w;
        for (int l = 0; l < NB; l++) if (w[l]) new_w[l*BW +: BW] = d[l*BW +: BW];
        if (w != '0) begin
          mem_m[a] = new_w;
          x.v      = 3'b011;
          x.hold   = 3'b100;
          x.d      = {old_w, old_w, new_w};
        end else begin
          x.v = 3'b111;
          x.d = {old_w, old_w, old_w};
        end
      end
      if (c) begin
        bz = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      end else if (bz > 0) begin
        bz--;
      end
    end
    exp_busy[cyc + 1] = (bz > 0);
    sbq.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b1, '0, a, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] w);
    step(1'b0, 1'b1, w, a, d, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = '0; addr = '0; di = '0; clr = 1'b0;
    bz = DEPTH;
    for (int m = 0; m < 3; m++) hold_do[m] = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // Reset, full sweep, then every address reads zero.
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(66);
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));

    // Full-word write, then partial lane write over it.
    wr(6'd5, 16'hBEEF, 2'b11);
    rd(6'd5);
    wr(6'd5, 16'h1234, 2'b01);
    rd(6'd5);
    wr(6'd7, 16'hCD00, 2'b10);
    rd(6'd7);
    wr(6'd63, 16'hA5A5, 2'b11);
    idle(2);
    rd(6'd63);
    idle(3);

    // Clear sweep; reads during it are ignored; restart at sweep cycle 30.
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 29; i++) rd(6'd5);
    step(1'b0, 1'b1, 2'b11, 6'd9, 16'h5555, 1'b1);
    for (int i = 0; i < 66; i++) rd(6'd63);
    rd(6'd5);

    // Reset in the middle of a sweep after writing a word.
    wr(6'd40, 16'hFFFF, 2'b11);
    rd(6'd40);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(9);
    step(1'b1, 1'b1, 2'b11, 6'd40, 16'hFFFF, 1'b0);
    idle(66);
    rd(6'd40);

    // Access and clr in the same cycle: access completes, then the clear.
    wr(6'd3, 16'h7777, 2'b11);
    step(1'b0, 1'b1, 2'b11, 6'd3, 16'h1111, 1'b1);
    idle(65);
    rd(6'd3);

    // Randomized traffic with occasional clr and rst.
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0),
           NB'($urandom_range(0, 3)), AW'($urandom_range(0, 15)),
           DW'($urandom), ($urandom_range(0, 249) == 0));
    end

    idle(LAT + 3);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
